mem_fft_pingpong: RTL and testbench

Parametrised ping-pong data memory for the radix-2 FFT datapath. Two dual-port banks alternate roles each stage: one is read for butterfly operands G/H while the other is written with results X/Y. The block adds a handshaked bit-reversed input load, a handshaked natural-order output unload and a sequencing FSM, and generalises point count and sample width. It sits between the FFT address/stage controller and the butterfly unit.

---
 rtl/mem_fft_pingpong.sv | 255 +++++++++++++++++++++++++
 tb/tb_mem_fft_pingpong.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fft_pingpong.sv
`default_nettype none
// ============================================================================
// Module      : mem_fft_pingpong
// Description : Ping-pong data memory for a radix-2 FFT datapath. Two
//               dual-port banks swap read/write roles on every stage. Input
//               samples are loaded in bit-reversed order with a valid/ready
//               handshake, and results are unloaded in natural order through
//               a 2-entry skid buffer that runs at one sample per cycle.
// Ports       : clk, clear_n (async, active low)
//               start / busy / frame_done       frame control and status
//               load_*                          input stream, natural order
//               rd_* , G_* , H_* , rd_valid     butterfly operand reads
//               wr_* , Xr/Xi/Yr/Yi              butterfly result writes
//               stage_done, compute_done        stage sequencing pulses
//               out_*                           output stream, natural order
//               src_bank, stage_cnt, err        status
// Revision    : 1.0 - initial release
// ============================================================================
module mem_fft_pingpong #(
    parameter int DW = 16,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          start,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [DW-1:0] load_real,
    input  logic [DW-1:0] load_imag,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_g_addr,
    input  logic [AW-1:0] rd_h_addr,
    output logic [DW-1:0] G_real,
    output logic [DW-1:0] G_imag,
    output logic [DW-1:0] H_real,
    output logic [DW-1:0] H_imag,
    output logic          rd_valid,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_g_addr,
    input  logic [AW-1:0] wr_h_addr,
    input  logic [DW-1:0] Xr,
    input  logic [DW-1:0] Xi,
    input  logic [DW-1:0] Yr,
    input  logic [DW-1:0] Yi,
    input  logic          stage_done,
    input  logic          compute_done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_real,
    output logic [DW-1:0] out_imag,
    output logic          out_last,
    output logic          src_bank,
    output logic [AW:0]   stage_cnt,
    output logic          busy,
    output logic          frame_done,
    output logic          err
);

    localparam int            c_N      = 1 << AW;
    localparam logic [AW:0]   c_N_PTS  = (AW+1)'(c_N);
    localparam logic [AW-1:0] c_LAST   = AW'(c_N - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_UNLOAD  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Each word packs {real, imag}
    logic [2*DW-1:0] r_bank0 [c_N];
    logic [2*DW-1:0] r_bank1 [c_N];

    logic [AW-1:0]   r_lcnt;
    logic            r_src_bank;
    logic [AW:0]     r_stage_cnt;
    logic            r_rd_valid;
    logic [2*DW-1:0] r_g_word;
    logic [2*DW-1:0] r_h_word;
    logic [AW:0]     r_ua;
    logic            r_ram_vld;
    logic [2*DW-1:0] r_ram_q;
    logic            r_ram_last;
    logic [2*DW-1:0] r_fq_data [2];
    logic            r_fq_last [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_cnt;
    logic            r_frame_done;
    logic            r_err;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
        return r;
    endfunction

    logic            w_load_acc;
    logic            w_compute;
    logic            w_rd;
    logic            w_wr;
    logic            w_swap;
    logic            w_pop;
    logic            w_head_last;
    logic [2:0]      w_occ;
    logic            w_issue;
    logic            w_err_set;
    logic [2*DW-1:0] w_g_word;
    logic [2*DW-1:0] w_h_word;
    logic [2*DW-1:0] w_u_word;

    assign w_load_acc  = (r_state == S_LOAD) && load_valid;
    assign w_compute   = (r_state == S_COMPUTE);
    assign w_rd        = w_compute && rd_en;
    assign w_wr        = w_compute && wr_en;
    assign w_swap      = w_compute && stage_done;
    assign w_pop       = out_valid && out_ready;
    assign w_head_last = r_fq_last[r_rd_ptr];

    // A read is issued only if the buffer can still hold it once the
    // in-flight word lands; counting this cycle's pop keeps the stream at
    // one sample per cycle while the sink is ready.
    assign w_occ   = 3'(r_cnt) + 3'(r_ram_vld) - 3'(w_pop);
    assign w_issue = (r_state == S_UNLOAD) && (r_ua < c_N_PTS) && (w_occ < 3'd2);

    assign w_g_word = r_src_bank ? r_bank1[rd_g_addr] : r_bank0[rd_g_addr];
    assign w_h_word = r_src_bank ? r_bank1[rd_h_addr] : r_bank0[rd_h_addr];
    assign w_u_word = r_src_bank ? r_bank1[r_ua[AW-1:0]] : r_bank0[r_ua[AW-1:0]];

    assign w_err_set = (load_valid && (r_state != S_LOAD))
                     || ((rd_en || wr_en || stage_done) && !w_compute)
                     || (wr_en && (wr_g_addr == wr_h_addr))
                     || (start && (r_state != S_IDLE));

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_LOAD;
            S_LOAD:    if (w_load_acc && (r_lcnt == c_LAST)) w_state_nxt = S_COMPUTE;
            S_COMPUTE: if (compute_done) w_state_nxt = S_UNLOAD;
            S_UNLOAD:  if (w_pop && w_head_last) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Bank storage has no reset; contents survive clear_n.
    // The G write is placed last so it wins when both addresses match.
    always_ff @(posedge clk) begin
        if (w_load_acc) r_bank0[bitrev(r_lcnt)] <= {load_real, load_imag};
        if (w_wr) begin
            if (r_src_bank) begin
                r_bank0[wr_h_addr] <= {Yr, Yi};
                r_bank0[wr_g_addr] <= {Xr, Xi};
            end else begin
                r_bank1[wr_h_addr] <= {Yr, Yi};
                r_bank1[wr_g_addr] <= {Xr, Xi};
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_lcnt       <= '0;
            r_src_bank   <= 1'b0;
            r_stage_cnt  <= '0;
            r_rd_valid   <= 1'b0;
            r_g_word     <= '0;
            r_h_word     <= '0;
            r_ua         <= '0;
            r_ram_vld    <= 1'b0;
            r_ram_q      <= '0;
            r_ram_last   <= 1'b0;
            r_fq_data[0] <= '0;
            r_fq_data[1] <= '0;
            r_fq_last[0] <= 1'b0;
            r_fq_last[1] <= 1'b0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) r_lcnt <= '0;
            else if (w_load_acc)              r_lcnt <= r_lcnt + 1'b1;

            // A stage_done that coincides with compute_done still swaps, so
            // the unload reads the bank that was just written.
            if (w_load_acc && (r_lcnt == c_LAST)) begin
                r_src_bank  <= 1'b0;
                r_stage_cnt <= '0;
            end else if (w_swap) begin
                r_src_bank <= ~r_src_bank;
                if (r_stage_cnt != '1) r_stage_cnt <= r_stage_cnt + 1'b1;
            end

            r_rd_valid <= w_rd;
            if (w_rd) begin
                r_g_word <= w_g_word;
                r_h_word <= w_h_word;
            end

            if (w_compute && compute_done) begin
                r_ua      <= '0;
                r_ram_vld <= 1'b0;
                r_cnt     <= '0;
                r_wr_ptr  <= 1'b0;
                r_rd_ptr  <= 1'b0;
            end else begin
                r_ram_vld <= w_issue;
                if (w_issue) begin
                    r_ram_q    <= w_u_word;
                    r_ram_last <= (r_ua[AW-1:0] == c_LAST);
                    r_ua       <= r_ua + 1'b1;
                end
                if (r_ram_vld) begin
                    r_fq_data[r_wr_ptr] <= r_ram_q;
                    r_fq_last[r_wr_ptr] <= r_ram_last;
                    r_wr_ptr            <= ~r_wr_ptr;
                end
                if (w_pop) r_rd_ptr <= ~r_rd_ptr;
                r_cnt <= r_cnt + 2'(r_ram_vld) - 2'(w_pop);
            end

            r_frame_done <= w_pop && w_head_last;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign load_ready = (r_state == S_LOAD);
    assign busy       = (r_state != S_IDLE);
    assign rd_valid   = r_rd_valid;
    assign G_real     = r_g_word[2*DW-1:DW];
    assign G_imag     = r_g_word[DW-1:0];
    assign H_real     = r_h_word[2*DW-1:DW];
    assign H_imag     = r_h_word[DW-1:0];
    assign out_valid  = (r_state == S_UNLOAD) && (r_cnt != 2'd0);
    assign out_last   = out_valid && w_head_last;
    assign out_real   = r_fq_data[r_rd_ptr][2*DW-1:DW];
    assign out_imag   = r_fq_data[r_rd_ptr][DW-1:0];
    assign src_bank   = r_src_bank;
    assign stage_cnt  = r_stage_cnt;
    assign frame_done = r_frame_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_fft_pingpong.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_fft_pingpong
// Description : Self-checking bench for mem_fft_pingpong. Keeps an array
//               model of both banks, loads ramp and random frames, runs
//               butterfly stages and checks the unloaded stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_fft_pingpong;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          clear_n;
    logic          start, load_valid, load_ready;
    logic [DW-1:0] load_real, load_imag;
    logic          rd_en;
    logic [AW-1:0] rd_g_addr, rd_h_addr;
    logic [DW-1:0] G_real, G_imag, H_real, H_imag;
    logic          rd_valid, wr_en;
    logic [AW-1:0] wr_g_addr, wr_h_addr;
    logic [DW-1:0] Xr, Xi, Yr, Yi;
    logic          stage_done, compute_done;
    logic          out_valid, out_ready, out_last;
    logic [DW-1:0] out_real, out_imag;
    logic          src_bank;
    logic [AW:0]   stage_cnt;
    logic          busy, frame_done, err;

    mem_fft_pingpong #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .clear_n(clear_n), .start(start),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_real(load_real), .load_imag(load_imag),
        .rd_en(rd_en), .rd_g_addr(rd_g_addr), .rd_h_addr(rd_h_addr),
        .G_real(G_real), .G_imag(G_imag), .H_real(H_real), .H_imag(H_imag),
        .rd_valid(rd_valid), .wr_en(wr_en), .wr_g_addr(wr_g_addr), .wr_h_addr(wr_h_addr),
        .Xr(Xr), .Xi(Xi), .Yr(Yr), .Yi(Yi),
        .stage_done(stage_done), .compute_done(compute_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag), .out_last(out_last),
        .src_bank(src_bank), .stage_cnt(stage_cnt), .busy(busy),
        .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: bank contents, read bank and stage count.
    logic [DW-1:0] mre [2][N];
    logic [DW-1:0] mim [2][N];
    int            msrc   = 0;
    int            mstage = 0;

    logic [DW-1:0] ld_re [N];
    logic [DW-1:0] ld_im [N];
    logic [DW-1:0] got_re [N];
    logic [DW-1:0] got_im [N];
    logic          got_last [N];

    typedef struct {
        int            beat;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          last;
    } ramp_vec_t;

    typedef struct {
        logic lv, rd, wr, sd, cd, st;
        logic exp_err, exp_busy;
    } err_vec_t;

    ramp_vec_t rv [6];
    err_vec_t  ev [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int brev(input int k);
        int r;
        int x;
        r = 0;
        x = k;
        for (int i = 0; i < AW; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic idle_inputs();
        start = 0; load_valid = 0; load_real = '0; load_imag = '0;
        rd_en = 0; rd_g_addr = '0; rd_h_addr = '0;
        wr_en = 0; wr_g_addr = '0; wr_h_addr = '0;
        Xr = '0; Xi = '0; Yr = '0; Yi = '0;
        stage_done = 0; compute_done = 0; out_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        clear_n = 0;
        repeat (2) @(negedge clk);
        clear_n = 1;
        @(negedge clk);
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) begin
            ld_re[k] = DW'($urandom);
            ld_im[k] = DW'($urandom);
        end
    endtask

    task automatic load_frame(input bit gaps);
        int k;
        start = 1;
        @(negedge clk);
        start = 0;
        chk("busy_after_start", busy, 1);
        chk("load_ready_after_start", load_ready, 1);
        k = 0;
        while (k < N) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                load_valid = 0;
            end else begin
                load_valid = 1;
                load_real  = ld_re[k];
                load_imag  = ld_im[k];
                mre[0][brev(k)] = ld_re[k];
                mim[0][brev(k)] = ld_im[k];
                k++;
            end
            @(negedge clk);
        end
        load_valid = 0;
        msrc   = 0;
        mstage = 0;
        chk("load_ready_after_load", load_ready, 0);
        chk("src_bank_after_load", src_bank, 0);
        chk("stage_cnt_after_load", stage_cnt, 0);
    endtask

    task automatic compute_done_pulse();
        compute_done = 1;
        @(negedge clk);
        compute_done = 0;
    endtask

    // One pass over all pairs (j, j+N/2): X = G + add, Y = H + add into the
    // destination bank. stage_done rides on the last write when sd_last=1.
    task automatic stage(input logic [DW-1:0] add, input bit sd_last, input bit cd);
        int dst;
        int h;
        logic [63:0] exp_gh;
        dst = 1 - msrc;
        for (int j = 0; j < N/2; j++) begin
            h = j + N/2;
            rd_en = 1; rd_g_addr = AW'(j); rd_h_addr = AW'(h);
            @(negedge clk);
            rd_en = 0;
            exp_gh = {mre[msrc][j], mim[msrc][j], mre[msrc][h], mim[msrc][h]};
            chk("rd_valid_high", rd_valid, 1);
            chk($sformatf("rd_gh_%0d", j), {G_real, G_imag, H_real, H_imag}, exp_gh);
            wr_en = 1; wr_g_addr = AW'(j); wr_h_addr = AW'(h);
            Xr = mre[msrc][j] + add; Xi = mim[msrc][j] + add;
            Yr = mre[msrc][h] + add; Yi = mim[msrc][h] + add;
            mre[dst][j] = Xr; mim[dst][j] = Xi;
            mre[dst][h] = Yr; mim[dst][h] = Yi;
            if (j == N/2 - 1 && sd_last) begin
                stage_done   = 1;
                compute_done = cd;
            end
            @(negedge clk);
            wr_en = 0; stage_done = 0; compute_done = 0;
            chk("rd_valid_low", rd_valid, 0);
            chk($sformatf("gh_hold_%0d", j), {G_real, G_imag, H_real, H_imag}, exp_gh);
        end
        if (!sd_last) begin
            stage_done = 1;
            @(negedge clk);
            stage_done = 0;
        end
        msrc = dst;
        if (mstage < 63) mstage++;
    endtask

    // Called on the first negedge after entering UNLOAD.
    task automatic unload(input int pct, input int stop_after);
        int beats;
        int cyc;
        int lat;
        bit held;
        logic [63:0] hold_val;
        beats = 0; cyc = 0; lat = 0; held = 0; hold_val = '0;
        out_ready = 0;
        chk("unload_busy", busy, 1);
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("first_valid_latency", lat, 2);
        while (beats < stop_after && cyc < 20 * N) begin
            if (held) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_data_held", {out_real, out_imag, out_last}, hold_val);
            end else if (pct == 100 && beats > 0) begin
                chk("no_bubble", out_valid, 1);
            end
            out_ready = ($urandom_range(0, 99) < pct);
            held = 0;
            if (out_valid) begin
                if (out_ready) begin
                    got_re[beats]   = out_real;
                    got_im[beats]   = out_imag;
                    got_last[beats] = out_last;
                    chk($sformatf("beat%0d_data", beats), {out_real, out_imag},
                        {mre[msrc][beats], mim[msrc][beats]});
                    chk($sformatf("beat%0d_last", beats), out_last, (beats == N - 1));
                    beats++;
                end else begin
                    held = 1;
                    hold_val = {out_real, out_imag, out_last};
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 0;
        if (beats < stop_after) chk("unload_timeout", beats, stop_after);
        if (stop_after == N) begin
            chk("frame_done_pulse", frame_done, 1);
            chk("busy_after_frame", busy, 0);
            chk("valid_after_frame", out_valid, 0);
            @(negedge clk);
            chk("frame_done_single", frame_done, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rv[0] = '{0,  16'd0,  16'd0,      1'b0};
        rv[1] = '{1,  16'd16, 16'hFFF0,   1'b0};
        rv[2] = '{2,  16'd8,  16'hFFF8,   1'b0};
        rv[3] = '{3,  16'd24, 16'hFFE8,   1'b0};
        rv[4] = '{30, 16'd15, 16'hFFF1,   1'b0};
        rv[5] = '{31, 16'd31, 16'hFFE1,   1'b1};
        //          lv rd wr sd cd st  err busy
        ev[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
        ev[1] = '{1, 0, 0, 0, 0, 0, 1, 0};
        ev[2] = '{0, 1, 0, 0, 0, 0, 1, 0};
        ev[3] = '{0, 0, 1, 0, 0, 0, 1, 0};
        ev[4] = '{0, 0, 0, 1, 0, 0, 1, 0};
        ev[5] = '{0, 0, 0, 0, 1, 0, 0, 0};
        ev[6] = '{0, 0, 0, 0, 0, 1, 0, 1};

        idle_inputs();
        clear_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err, 0);
        chk("rst_src_bank", src_bank, 0);
        chk("rst_stage_cnt", stage_cnt, 0);
        chk("rst_gh", {G_real, G_imag, H_real, H_imag}, 0);
        chk("rst_out_data", {out_real, out_imag}, 0);
        clear_n = 1;
        @(negedge clk);

        // Single-cycle protocol vectors applied in IDLE
        for (int i = 0; i < 7; i++) begin
            do_reset();
            load_valid = ev[i].lv; rd_en = ev[i].rd; wr_en = ev[i].wr;
            wr_g_addr = 5'd20; wr_h_addr = 5'd21;
            stage_done = ev[i].sd; compute_done = ev[i].cd; start = ev[i].st;
            @(negedge clk);
            idle_inputs();
            chk($sformatf("vec%0d_err", i), err, ev[i].exp_err);
            chk($sformatf("vec%0d_busy", i), busy, ev[i].exp_busy);
        end

        // Ramp frame, straight to unload
        do_reset();
        for (int k = 0; k < N; k++) begin
            ld_re[k] = DW'(k);
            ld_im[k] = DW'(-k);
        end
        load_frame(0);
        compute_done_pulse();
        unload(100, N);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("ramp_beat%0d", rv[i].beat),
                {got_re[rv[i].beat], got_im[rv[i].beat], got_last[rv[i].beat]},
                {rv[i].re, rv[i].im, rv[i].last});
        end

        // One +1 stage, last write shares the cycle with stage_done
        fill_random();
        load_frame(1);
        stage(16'd1, 1, 0);
        chk("one_stage_src_bank", src_bank, 1);
        chk("one_stage_cnt", stage_cnt, 1);
        rd_en = 1; rd_g_addr = AW'(N/2 - 1); rd_h_addr = AW'(N - 1);
        @(negedge clk);
        rd_en = 0;
        chk("swap_write_readback", {G_real, G_imag, H_real, H_imag},
            {mre[msrc][N/2-1], mim[msrc][N/2-1], mre[msrc][N-1], mim[msrc][N-1]});
        compute_done_pulse();
        unload(50, N);

        // Five identity stages; compute_done rides on the final stage_done
        fill_random();
        load_frame(1);
        for (int s = 0; s < 5; s++) stage(16'd0, (s % 2 == 0), (s == 4));
        chk("five_stage_src_bank", src_bank, 1);
        chk("five_stage_cnt", stage_cnt, 5);
        unload(50, N);

        // start while busy is ignored but flagged
        do_reset();
        start = 1;
        @(negedge clk);
        @(negedge clk);
        start = 0;
        @(negedge clk);
        chk("start_busy_err", err, 1);
        chk("start_busy_still_load", load_ready, 1);

        // rd_en in IDLE sets a sticky error cleared only by reset
        do_reset();
        chk("idle_err_clear", err, 0);
        rd_en = 1;
        @(negedge clk);
        rd_en = 0;
        chk("idle_rd_err", err, 1);
        chk("idle_rd_no_valid", rd_valid, 0);
        repeat (5) @(negedge clk);
        chk("idle_rd_err_sticky", err, 1);
        do_reset();
        chk("err_cleared_by_reset", err, 0);

        // Colliding write addresses: flagged, port G wins
        fill_random();
        load_frame(1);
        wr_en = 1; wr_g_addr = 5'd7; wr_h_addr = 5'd7;
        Xr = 16'hA5A5; Xi = 16'h5A5A; Yr = 16'h1234; Yi = 16'h4321;
        @(negedge clk);
        wr_en = 0;
        mre[1][7] = 16'hA5A5; mim[1][7] = 16'h5A5A;
        chk("collide_err", err, 1);
        stage_done = 1;
        @(negedge clk);
        stage_done = 0;
        msrc = 1;
        rd_en = 1; rd_g_addr = 5'd7; rd_h_addr = 5'd7;
        @(negedge clk);
        rd_en = 0;
        chk("collide_g_wins", {G_real, G_imag, H_real, H_imag},
            {16'hA5A5, 16'h5A5A, 16'hA5A5, 16'h5A5A});
        compute_done_pulse();
        unload(100, 10);
        chk("pre_reset_valid", out_valid, 1);
        chk("pre_reset_err", err, 1);
        #2;
        clear_n = 0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_err", err, 0);
        @(negedge clk);
        clear_n = 1;
        @(negedge clk);
        chk("post_reset_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
